// File: rtl/fetchbuffer_queue_if.sv
// Fetch-side bundle of the prefetch queue: redirect, instruction output and imem request/response channels.
// The master modport is the queue itself; slave is the core/memory environment around it.
interface fetchbuffer_queue_if;
    logic        redir_valid;
    logic [31:0] redir_addr;
    logic [1:0]  redir_mode;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_error;

    logic        imem_valid;
    logic        imem_gnt;
    logic [31:0] imem_addr;
    logic [1:0]  imem_mode;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_error;

    modport master (
        input  redir_valid, redir_addr, redir_mode,
        input  out_ready, imem_gnt, imem_ready, imem_rdata, imem_error,
        output out_valid, out_instr, out_pc, out_error,
        output imem_valid, imem_addr, imem_mode
    );

    modport slave (
        output redir_valid, redir_addr, redir_mode,
        output out_ready, imem_gnt, imem_ready, imem_rdata, imem_error,
        input  out_valid, out_instr, out_pc, out_error,
        input  imem_valid, imem_addr, imem_mode
    );
endinterface

// File: rtl/fetchbuffer_queue.sv
// Prefetch queue: circular FIFO of fetched words with bounded in-flight requests,
// 16/32-bit instruction realignment across word boundaries, and single-cycle redirect flush.
module fetchbuffer_queue #(
    parameter int          DEPTH       = 8,
    parameter int          OUTSTANDING = 2,
    parameter logic [31:0] RESET_ADDR  = 32'h0,
    parameter logic [1:0]  RESET_MODE  = 2'b11
) (
    input logic                 clk,
    input logic                 rst,
    fetchbuffer_queue_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(OUTSTANDING + 1);
    localparam int SW = ((CW > IW) ? CW : IW) + 1;

    logic [31:0]   entry_data [DEPTH];
    logic          entry_err  [DEPTH];

    logic [AW-1:0] head, tail, head_next;
    logic [CW-1:0] count;
    logic [IW-1:0] inflight, inflight_next, drop;
    logic [31:0]   pc, fetch_addr;
    logic [1:0]    mode;
    logic          halt;

    logic [31:0]   head_word, next_word, instr;
    logic          head_err, next_err;
    logic          avail, is32, err, fire, pop, grant, resp, write;
    logic [SW-1:0] occupancy;

    assign head_next = head + AW'(1);
    assign head_word = entry_data[head];
    assign head_err  = entry_err[head];
    assign next_word = entry_data[head_next];
    assign next_err  = entry_err[head_next];

    // Decode the instruction at pc from the head entry, borrowing the next entry when it straddles
    always_comb begin
        avail = 1'b0;
        is32  = 1'b0;
        err   = 1'b0;
        instr = 32'h0;
        if (count != '0) begin
            if (!pc[1]) begin
                avail = 1'b1;
                is32  = (head_word[1:0] == 2'b11);
                err   = head_err;
                instr = is32 ? head_word : {16'h0, head_word[15:0]};
            end else if (head_word[17:16] != 2'b11) begin
                avail = 1'b1;
                err   = head_err;
                instr = {16'h0, head_word[31:16]};
            end else begin
                is32 = 1'b1;
                if (count >= CW'(2)) begin
                    avail = 1'b1;
                    err   = head_err | next_err;
                    instr = {next_word[15:0], head_word[31:16]};
                end else begin
                    avail = head_err;
                    err   = head_err;
                end
            end
        end
        if (err) begin
            instr = 32'h0;
        end
    end

    assign bus.out_valid = avail && !halt && !bus.redir_valid;
    assign bus.out_instr = instr;
    assign bus.out_error = err;
    assign bus.out_pc    = pc;

    // Occupancy counts reserved slots so every granted word is guaranteed a place on return
    assign occupancy      = SW'(count) + SW'(inflight);
    assign bus.imem_valid = rst && !halt && !bus.redir_valid &&
                            (inflight < IW'(OUTSTANDING)) && (occupancy < SW'(DEPTH));
    assign bus.imem_addr  = fetch_addr;
    assign bus.imem_mode  = mode;

    assign fire  = bus.out_valid && bus.out_ready;
    assign pop   = fire && (pc[1] || is32);
    assign grant = bus.imem_valid && bus.imem_gnt;
    assign resp  = bus.imem_ready;
    assign write = resp && (drop == '0) && !bus.redir_valid;

    assign inflight_next = inflight + IW'(grant) - IW'(resp);

    always_ff @(posedge clk) begin
        if (write) begin
            entry_data[tail] <= bus.imem_rdata;
            entry_err[tail]  <= bus.imem_error;
        end
    end

    // A redirect keeps inflight but marks every owed response as stale via drop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            inflight   <= '0;
            drop       <= '0;
            pc         <= RESET_ADDR;
            fetch_addr <= RESET_ADDR;
            mode       <= RESET_MODE;
            halt       <= 1'b0;
        end else begin
            inflight <= inflight_next;
            if (bus.redir_valid) begin
                count      <= '0;
                head       <= tail;
                pc         <= bus.redir_addr & 32'hFFFF_FFFE;
                fetch_addr <= bus.redir_addr & 32'hFFFF_FFFC;
                mode       <= bus.redir_mode;
                halt       <= 1'b0;
                drop       <= inflight_next;
            end else begin
                if (grant) begin
                    fetch_addr <= fetch_addr + 32'd4;
                end
                if (resp && (drop != '0)) begin
                    drop <= drop - IW'(1);
                end
                if (write) begin
                    tail <= tail + AW'(1);
                end
                if (pop) begin
                    head <= head_next;
                end
                count <= count + CW'(write) - CW'(pop);
                if (fire) begin
                    pc <= pc + (is32 ? 32'd4 : 32'd2);
                    if (err) begin
                        halt <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_fetchbuffer_queue.sv
// Randomized and directed bench for fetchbuffer_queue against an instruction-stream reference model
// that decodes straight from a byte-level view of a small backing memory.
module tb_fetchbuffer_queue;
    localparam int          DEPTH       = 8;
    localparam int          OUTSTANDING = 2;
    localparam logic [31:0] RESET_ADDR  = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b0;

    fetchbuffer_queue_if bus();

    fetchbuffer_queue #(
        .DEPTH(DEPTH), .OUTSTANDING(OUTSTANDING), .RESET_ADDR(RESET_ADDR), .RESET_MODE(2'b11)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int gnt_pct, rsp_pct, rdy_pct;

    logic [31:0] mem_word [128];
    logic        mem_err  [128];
    logic [31:0] pend_addr [$];
    int          pend_cyc  [$];

    logic [31:0] exp_pc, exp_fetch;
    logic [1:0]  exp_mode;
    bit          halted;

    function automatic logic [15:0] half_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word[a[8:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    function automatic logic err_at(input logic [31:0] a);
        return mem_err[a[8:2]];
    endfunction

    // Reference decode: the instruction at byte address pc, its size and whether any touched word faulted
    function automatic void model_instr(input logic [31:0] pc, output logic [31:0] ins,
                                        output logic er, output int sz);
        logic [15:0] h0, h1;
        h0 = half_at(pc);
        if (h0[1:0] != 2'b11) begin
            sz  = 2;
            ins = {16'h0, h0};
            er  = err_at(pc);
        end else begin
            sz  = 4;
            h1  = half_at(pc + 32'd2);
            ins = {h1, h0};
            er  = err_at(pc) | err_at(pc + 32'd2);
        end
        if (er) ins = 32'h0;
    endfunction

    function automatic logic [31:0] q_at(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    task automatic fill_mem(input logic [31:0] w);
        for (int i = 0; i < 128; i++) begin
            mem_word[i] = w;
            mem_err[i]  = 1'b0;
        end
    endtask

    task automatic init_inputs();
        bus.redir_valid = 1'b0;
        bus.redir_addr  = 32'h0;
        bus.redir_mode  = 2'b00;
        bus.out_ready   = 1'b0;
        bus.imem_gnt    = 1'b0;
        bus.imem_ready  = 1'b0;
        bus.imem_rdata  = 32'h0;
        bus.imem_error  = 1'b0;
    endtask

    task automatic clear_model();
        pend_addr.delete();
        pend_cyc.delete();
        exp_pc    = RESET_ADDR;
        exp_fetch = RESET_ADDR;
        exp_mode  = 2'b11;
        halted    = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        init_inputs();
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Drive one cycle of inputs (memory behaves in order, at least one cycle after grant), then settle at negedge
    task automatic drive(input bit rdir, input logic [31:0] raddr, input logic [1:0] rmode);
        logic [31:0] a;
        bus.redir_valid = rdir;
        bus.redir_addr  = raddr;
        bus.redir_mode  = rmode;
        bus.imem_gnt    = ($urandom_range(99) < gnt_pct);
        bus.out_ready   = ($urandom_range(99) < rdy_pct);
        bus.imem_ready  = 1'b0;
        bus.imem_rdata  = $urandom;
        bus.imem_error  = 1'b0;
        if (pend_addr.size() > 0 && pend_cyc[0] < cyc && $urandom_range(99) < rsp_pct) begin
            a = pend_addr[0];
            bus.imem_ready = 1'b1;
            bus.imem_rdata = mem_word[a[8:2]];
            bus.imem_error = mem_err[a[8:2]];
        end
        @(negedge clk);
    endtask

    task automatic advance();
        bit          grant, resp, fire;
        logic [31:0] gaddr, ins;
        logic        er;
        int          sz;
        grant = bus.imem_valid && bus.imem_gnt;
        gaddr = bus.imem_addr;
        resp  = bus.imem_ready;
        fire  = bus.out_valid && bus.out_ready;
        if (bus.redir_valid) begin
            exp_pc    = bus.redir_addr & 32'hFFFF_FFFE;
            exp_fetch = bus.redir_addr & 32'hFFFF_FFFC;
            exp_mode  = bus.redir_mode;
            halted    = 1'b0;
        end else begin
            if (fire) begin
                model_instr(exp_pc, ins, er, sz);
                exp_pc = exp_pc + 32'(sz);
                if (er) halted = 1'b1;
            end
            if (grant) exp_fetch = exp_fetch + 32'd4;
        end
        @(posedge clk);
        #1;
        if (resp && pend_addr.size() > 0) begin
            void'(pend_addr.pop_front());
            void'(pend_cyc.pop_front());
        end
        if (grant) begin
            pend_addr.push_back(gaddr);
            pend_cyc.push_back(cyc);
        end
        cyc++;
    endtask

    task automatic test_reset();
        init_inputs();
        clear_model();
        rst = 1'b0;
        @(negedge clk);
        if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++;
        if (bus.imem_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_imem_valid: got %b expected 0", bus.imem_valid); end
        checks++;
        if (bus.out_pc !== RESET_ADDR) begin errors++; $display("[TB] FAIL reset_out_pc: got %h expected %h", bus.out_pc, RESET_ADDR); end
        checks++;
        if (bus.imem_addr !== RESET_ADDR) begin errors++; $display("[TB] FAIL reset_imem_addr: got %h expected %h", bus.imem_addr, RESET_ADDR); end
        checks++;
        if (bus.out_error !== 1'b0 || bus.out_instr !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_out_instr: got %b/%h expected 0/00000000", bus.out_error, bus.out_instr);
        end
        checks++;
        @(posedge clk);
        #1 rst = 1'b1;
        gnt_pct = 0; rsp_pct = 0; rdy_pct = 0;
        drive(1'b0, 32'h0, 2'b00);
        if (bus.imem_valid !== 1'b1 || bus.imem_addr !== RESET_ADDR || bus.imem_mode !== 2'b11) begin
            errors++; $display("[TB] FAIL first_request: got %b %h %b expected 1 %h 11", bus.imem_valid, bus.imem_addr, bus.imem_mode, RESET_ADDR);
        end
        checks++;
        advance();
    endtask

    task automatic test_basic();
        logic [31:0] f_pc[$], f_ins[$], g_addr[$];
        fill_mem(32'h0000_0013);
        mem_word[1] = 32'h0010_0093;
        apply_reset();
        gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
        repeat (12) begin
            drive(1'b0, 32'h0, 2'b00);
            if (bus.out_valid && bus.out_ready) begin f_pc.push_back(bus.out_pc); f_ins.push_back(bus.out_instr); end
            if (bus.imem_valid && bus.imem_gnt) g_addr.push_back(bus.imem_addr);
            advance();
        end
        if (q_at(f_ins, 0) !== 32'h0000_0013 || q_at(f_pc, 0) !== 32'h0) begin
            errors++; $display("[TB] FAIL basic_first: got %h@%h expected 00000013@00000000", q_at(f_ins, 0), q_at(f_pc, 0));
        end
        checks++;
        if (q_at(f_ins, 1) !== 32'h0010_0093 || q_at(f_pc, 1) !== 32'h4) begin
            errors++; $display("[TB] FAIL basic_second: got %h@%h expected 00100093@00000004", q_at(f_ins, 1), q_at(f_pc, 1));
        end
        checks++;
        if (q_at(g_addr, 0) !== 32'h0 || q_at(g_addr, 1) !== 32'h4 || q_at(g_addr, 2) !== 32'h8) begin
            errors++; $display("[TB] FAIL basic_imem_addr: got %h,%h,%h expected 0,4,8", q_at(g_addr, 0), q_at(g_addr, 1), q_at(g_addr, 2));
        end
        checks++;
    endtask

    task automatic test_realign();
        logic [31:0] f_pc[$], f_ins[$];
        fill_mem(32'h0000_0013);
        mem_word[0] = 32'h0093_4501;
        mem_word[1] = 32'h0012_0001;
        apply_reset();
        gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
        repeat (12) begin
            drive(1'b0, 32'h0, 2'b00);
            if (bus.out_valid && bus.out_ready) begin f_pc.push_back(bus.out_pc); f_ins.push_back(bus.out_instr); end
            advance();
        end
        if (q_at(f_ins, 0) !== 32'h0000_4501 || q_at(f_pc, 0) !== 32'h0) begin
            errors++; $display("[TB] FAIL realign_c16: got %h@%h expected 00004501@00000000", q_at(f_ins, 0), q_at(f_pc, 0));
        end
        checks++;
        if (q_at(f_ins, 1) !== 32'h0001_0093 || q_at(f_pc, 1) !== 32'h2) begin
            errors++; $display("[TB] FAIL realign_split32: got %h@%h expected 00010093@00000002", q_at(f_ins, 1), q_at(f_pc, 1));
        end
        checks++;
        if (q_at(f_ins, 2) !== 32'h0000_0012 || q_at(f_pc, 2) !== 32'h6) begin
            errors++; $display("[TB] FAIL realign_upper16: got %h@%h expected 00000012@00000006", q_at(f_ins, 2), q_at(f_pc, 2));
        end
        checks++;
    endtask

    task automatic test_full();
        int  grants = 0;
        bit  fired = 1'b0;
        fill_mem(32'h0000_0013);
        apply_reset();
        gnt_pct = 100; rsp_pct = 100; rdy_pct = 0;
        repeat (30) begin
            drive(1'b0, 32'h0, 2'b00);
            if (bus.imem_valid && bus.imem_gnt) grants++;
            advance();
        end
        drive(1'b0, 32'h0, 2'b00);
        if (grants != DEPTH || bus.imem_valid !== 1'b0 || pend_addr.size() != 0 || bus.out_valid !== 1'b1) begin
            errors++; $display("[TB] FAIL full_stall: got grants=%0d imem_valid=%b owed=%0d out_valid=%b expected %0d 0 0 1",
                               grants, bus.imem_valid, pend_addr.size(), bus.out_valid, DEPTH);
        end
        checks++;
        advance();
        rdy_pct = 100;
        drive(1'b0, 32'h0, 2'b00);
        fired = bus.out_valid && bus.out_ready;
        advance();
        rdy_pct = 0;
        grants = 0;
        repeat (20) begin
            drive(1'b0, 32'h0, 2'b00);
            if (bus.imem_valid && bus.imem_gnt) grants++;
            advance();
        end
        if (!fired || grants != 1) begin
            errors++; $display("[TB] FAIL full_refill: got accept=%b grants=%0d expected 1 1", fired, grants);
        end
        checks++;
    endtask

    task automatic test_redirect();
        logic [31:0] f_pc[$], f_ins[$], g_addr[$];
        logic [1:0]  g_mode = 2'b00;
        fill_mem(32'h00A0_0093);
        mem_word[64] = 32'h0050_0093;
        mem_word[65] = 32'h0060_0093;
        apply_reset();
        gnt_pct = 100; rsp_pct = 0; rdy_pct = 100;
        repeat (2) begin drive(1'b0, 32'h0, 2'b00); advance(); end
        if (pend_addr.size() != OUTSTANDING) begin
            errors++; $display("[TB] FAIL redir_owed: got %0d expected %0d", pend_addr.size(), OUTSTANDING);
        end
        checks++;
        drive(1'b1, 32'h100, 2'b01);
        if (bus.out_valid !== 1'b0 || bus.imem_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL redir_cycle: got out_valid=%b imem_valid=%b expected 0 0", bus.out_valid, bus.imem_valid);
        end
        checks++;
        advance();
        rsp_pct = 100;
        repeat (20) begin
            drive(1'b0, 32'h0, 2'b00);
            if (bus.out_valid && bus.out_ready) begin f_pc.push_back(bus.out_pc); f_ins.push_back(bus.out_instr); end
            if (bus.imem_valid && bus.imem_gnt) begin
                if (g_addr.size() == 0) g_mode = bus.imem_mode;
                g_addr.push_back(bus.imem_addr);
            end
            advance();
        end
        if (q_at(g_addr, 0) !== 32'h100 || g_mode !== 2'b01) begin
            errors++; $display("[TB] FAIL redir_request: got %h mode %b expected 00000100 mode 01", q_at(g_addr, 0), g_mode);
        end
        checks++;
        if (q_at(f_ins, 0) !== 32'h0050_0093 || q_at(f_pc, 0) !== 32'h100) begin
            errors++; $display("[TB] FAIL redir_first: got %h@%h expected 00500093@00000100", q_at(f_ins, 0), q_at(f_pc, 0));
        end
        checks++;
        if (q_at(f_ins, 1) !== 32'h0060_0093 || q_at(f_pc, 1) !== 32'h104) begin
            errors++; $display("[TB] FAIL redir_second: got %h@%h expected 00600093@00000104", q_at(f_ins, 1), q_at(f_pc, 1));
        end
        checks++;
    endtask

    task automatic test_error();
        logic [31:0] f_pc[$], f_ins[$], f_err[$];
        int  leaks = 0;
        bit  seen = 1'b0;
        fill_mem(32'h0000_0013);
        mem_err[2] = 1'b1;
        apply_reset();
        gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
        repeat (25) begin
            drive(1'b0, 32'h0, 2'b00);
            if (seen && (bus.out_valid || bus.imem_valid)) leaks++;
            if (bus.out_valid && bus.out_ready) begin
                f_pc.push_back(bus.out_pc); f_ins.push_back(bus.out_instr); f_err.push_back({31'h0, bus.out_error});
                if (bus.out_error) seen = 1'b1;
            end
            advance();
        end
        if (q_at(f_err, 2) !== 32'h1 || q_at(f_ins, 2) !== 32'h0 || q_at(f_pc, 2) !== 32'h8 || q_at(f_err, 0) !== 32'h0) begin
            errors++; $display("[TB] FAIL error_report: got err=%h instr=%h pc=%h expected 1 00000000 00000008", q_at(f_err, 2), q_at(f_ins, 2), q_at(f_pc, 2));
        end
        checks++;
        if (f_pc.size() != 3 || leaks != 0) begin
            errors++; $display("[TB] FAIL error_halt: got accepts=%0d leaks=%0d expected 3 0", f_pc.size(), leaks);
        end
        checks++;
        drive(1'b1, 32'h0, 2'b11);
        advance();
        f_pc.delete();
        repeat (10) begin
            drive(1'b0, 32'h0, 2'b00);
            if (bus.out_valid && bus.out_ready) f_pc.push_back(bus.out_pc);
            advance();
        end
        if (q_at(f_pc, 0) !== 32'h0) begin
            errors++; $display("[TB] FAIL error_restart: got %h expected 00000000", q_at(f_pc, 0));
        end
        checks++;
    endtask

    task automatic test_async_reset();
        logic [31:0] f_pc[$], f_ins[$], g_addr[$];
        fill_mem(32'h0000_0013);
        mem_word[0] = 32'h0000_0513;
        apply_reset();
        gnt_pct = 100; rsp_pct = 100; rdy_pct = 100;
        repeat (6) begin drive(1'b0, 32'h0, 2'b00); advance(); end
        #2 rst = 1'b0;
        init_inputs();
        clear_model();
        #1;
        if (bus.out_valid !== 1'b0 || bus.imem_valid !== 1'b0 || bus.out_pc !== RESET_ADDR || bus.imem_addr !== RESET_ADDR) begin
            errors++; $display("[TB] FAIL async_reset: got out_valid=%b imem_valid=%b pc=%h addr=%h expected 0 0 %h %h",
                               bus.out_valid, bus.imem_valid, bus.out_pc, bus.imem_addr, RESET_ADDR, RESET_ADDR);
        end
        checks++;
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (10) begin
            drive(1'b0, 32'h0, 2'b00);
            if (bus.out_valid && bus.out_ready) begin f_pc.push_back(bus.out_pc); f_ins.push_back(bus.out_instr); end
            if (bus.imem_valid && bus.imem_gnt) g_addr.push_back(bus.imem_addr);
            advance();
        end
        if (q_at(g_addr, 0) !== RESET_ADDR || q_at(f_pc, 0) !== RESET_ADDR || q_at(f_ins, 0) !== 32'h0000_0513) begin
            errors++; $display("[TB] FAIL async_restart: got addr=%h %h@%h expected %h 00000513@%h",
                               q_at(g_addr, 0), q_at(f_ins, 0), q_at(f_pc, 0), RESET_ADDR, RESET_ADDR);
        end
        checks++;
    endtask

    task automatic test_random();
        logic [31:0] ins;
        logic        er;
        int          sz;
        int          accepted = 0;
        for (int i = 0; i < 128; i++) begin
            mem_word[i] = $urandom;
            mem_err[i]  = ($urandom_range(23) == 0);
        end
        apply_reset();
        gnt_pct = 70; rsp_pct = 60; rdy_pct = 70;
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(39) == 0, 32'($urandom_range(511)), 2'($urandom_range(3)));
            if (bus.imem_valid) begin
                if (bus.imem_addr !== exp_fetch || bus.imem_mode !== exp_mode) begin
                    errors++; $display("[TB] FAIL rand_request: got %h/%b expected %h/%b", bus.imem_addr, bus.imem_mode, exp_fetch, exp_mode);
                end
                checks++;
                if (halted || bus.redir_valid) begin
                    errors++; $display("[TB] FAIL rand_issue_gate: got imem_valid=1 expected 0 (halted=%b redir=%b)", halted, bus.redir_valid);
                end
                checks++;
            end
            if (bus.out_valid) begin
                model_instr(exp_pc, ins, er, sz);
                if (halted) begin
                    errors++; $display("[TB] FAIL rand_halt: got out_valid=1 expected 0");
                end
                checks++;
                if (bus.out_pc !== exp_pc || bus.out_instr !== ins || bus.out_error !== er) begin
                    errors++; $display("[TB] FAIL rand_instr: got %h@%h err=%b expected %h@%h err=%b",
                                       bus.out_instr, bus.out_pc, bus.out_error, ins, exp_pc, er);
                end
                checks++;
                if (bus.out_ready) accepted++;
            end
            advance();
            if (pend_addr.size() > OUTSTANDING) begin
                errors++; $display("[TB] FAIL rand_outstanding: got %0d expected <= %0d", pend_addr.size(), OUTSTANDING);
            end
            checks++;
        end
        if (accepted < 300) begin
            errors++; $display("[TB] FAIL rand_progress: got %0d accepts expected >= 300", accepted);
        end
        checks++;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        fill_mem(32'h0000_0013);
        test_reset();
        test_basic();
        test_realign();
        test_full();
        test_redirect();
        test_error();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
